// File: rtl/acc_sched_pkg.sv
// Shared types and default sizing for the accumulate sequencer.
package acc_sched_pkg;

   localparam int unsigned STEPS_DEF = 16;
   localparam int unsigned DW_DEF    = 6;
   // Width of the step index and cfg_last
   localparam int unsigned SW        = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/acc_sched_dp.sv
// acc_dp: W/B accumulator datapath.
//   clk, reset : clock, async active-low reset
//   clr        : zero W and B
//   load_w     : W <= W + B
//   cnt        : B <= B + 1
//   w          : current accumulator value
// load_w and cnt may both be set; each uses the pre-edge W and B.
module acc_dp #(
   parameter int unsigned DW = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          load_w,
   input  logic          cnt,
   output logic [DW-1:0] w
);

   logic [DW-1:0] b;

   // Accumulator and counter, modulo 2^DW
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w <= '0;
         b <= '0;
      end else if (clr) begin
         w <= '0;
         b <= '0;
      end else begin
         if (load_w) w <= w + b;
         if (cnt)    b <= b + DW'(1);
      end
   end

endmodule

// File: rtl/acc_sched.sv
// acc_sched: job sequencer that runs up to STEPS load/count steps on acc_dp.
//   clk, reset                  : clock, async active-low reset
//   start_valid / start_ready   : job offer handshake
//   cfg_load_mask, cfg_cnt_mask : per-step W+=B / B+=1 selects
//   cfg_last                    : index of the final step
//   abort                       : cancel a job in CLEAR or RUN
//   result_valid / result_ready : result handshake
//   result                      : final accumulator W
//   busy, step                  : status
module acc_sched
   import acc_sched_pkg::*;
#(
   parameter int unsigned STEPS = STEPS_DEF,
   parameter int unsigned DW    = DW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [STEPS-1:0] cfg_load_mask,
   input  logic [STEPS-1:0] cfg_cnt_mask,
   input  logic [SW-1:0]    cfg_last,
   input  logic             abort,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [DW-1:0]    result,
   output logic             busy,
   output logic [SW-1:0]    step
);

   state_t           state_q, state_d;
   logic [STEPS-1:0] load_mask_q, cnt_mask_q;
   logic [SW-1:0]    last_q;
   logic             accept, clr, load_w, cnt;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and datapath controls; abort suppresses the step it coincides with
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      clr     = 1'b0;
      load_w  = 1'b0;
      cnt     = 1'b0;
      case (state_q)
         IDLE: begin
            accept = start_valid && start_ready;
            if (accept) state_d = CLEAR;
         end
         CLEAR: begin
            if (abort) state_d = IDLE;
            else begin
               clr     = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (abort) state_d = IDLE;
            else begin
               load_w = load_mask_q[step];
               cnt    = cnt_mask_q[step];
               if (step == last_q) state_d = DONE;
            end
         end
         DONE: begin
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered status outputs, computed from the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_ready  <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         step         <= '0;
      end else begin
         start_ready  <= (state_d == IDLE);
         busy         <= (state_d != IDLE);
         result_valid <= (state_d == DONE);
         step         <= (state_d == RUN && state_q == RUN) ? step + SW'(1) : '0;
      end
   end

   // Job configuration, captured only on accept
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_mask_q <= '0;
         cnt_mask_q  <= '0;
         last_q      <= '0;
      end else if (accept) begin
         load_mask_q <= cfg_load_mask;
         cnt_mask_q  <= cfg_cnt_mask;
         last_q      <= cfg_last;
      end
   end

   acc_dp #(.DW(DW)) u_dp (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
      .load_w (load_w),
      .cnt    (cnt),
      .w      (result)
   );

endmodule

// File: tb/tb_acc_sched.sv
// Scoreboard bench for acc_sched: driver pushes expected result and arrival
// cycle per job; an independent monitor pops on each result_valid rise.
module tb_acc_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_valid;
   logic        start_ready;
   logic [15:0] cfg_load_mask;
   logic [15:0] cfg_cnt_mask;
   logic [3:0]  cfg_last;
   logic        abort;
   logic        result_valid;
   logic        result_ready;
   logic [5:0]  result;
   logic        busy;
   logic [3:0]  step;

   typedef struct {
      logic [5:0] res;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   nvec = 0;
   int   nerr = 0;
   int   cyc  = 0;

   acc_sched dut (
      .clk           (clk),
      .reset         (reset),
      .start_valid   (start_valid),
      .start_ready   (start_ready),
      .cfg_load_mask (cfg_load_mask),
      .cfg_cnt_mask  (cfg_cnt_mask),
      .cfg_last      (cfg_last),
      .abort         (abort),
      .result_valid  (result_valid),
      .result_ready  (result_ready),
      .result        (result),
      .busy          (busy),
      .step          (step)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare each new result against the scoreboard head
   initial begin : monitor
      logic rv_prev;
      exp_t e;
      rv_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && result_valid === 1'b1 && !rv_prev) begin
            if (sb.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL spurious_result: got value %0d expected no result", result);
            end else begin
               e = sb.pop_front();
               check("result_value", 32'(result), 32'(e.res));
               check("result_latency", 32'(cyc), 32'(e.cyc));
            end
         end
         rv_prev = (result_valid === 1'b1);
      end
   end

   // Offer a job at the next negedge; accept happens on the following posedge
   task automatic offer(input logic [15:0] lm, input logic [15:0] cm, input logic [3:0] last);
      @(negedge clk);
      check("start_ready_idle", 32'(start_ready), 32'd1);
      cfg_load_mask = lm;
      cfg_cnt_mask  = cm;
      cfg_last      = last;
      start_valid   = 1'b1;
   endtask

   task automatic do_job(input logic [15:0] lm, input logic [15:0] cm, input logic [3:0] last,
                         input logic [5:0] exp, input int hold, input bit scramble);
      int   n;
      exp_t e;
      offer(lm, cm, last);
      e.res = exp;
      e.cyc = cyc + 32'(last) + 3;
      sb.push_back(e);
      result_ready = (hold == 0);
      @(negedge clk);
      start_valid = 1'b0;
      if (scramble) begin
         cfg_load_mask = '0;
         cfg_cnt_mask  = '0;
         cfg_last      = '0;
      end
      n = 0;
      while (result_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (result_valid !== 1'b1) begin
         nvec++;
         nerr++;
         $display("FAIL job_timeout: got no result_valid expected one within 40 cycles");
         result_ready = 1'b1;
         return;
      end
      for (int i = 0; i < hold; i++) begin
         check("bp_result_stable", 32'(result), 32'(exp));
         check("bp_start_ready", 32'(start_ready), 32'd0);
         check("bp_valid_held", 32'(result_valid), 32'd1);
         abort = 1'b1;
         @(negedge clk);
      end
      abort        = 1'b0;
      result_ready = 1'b1;
      @(negedge clk);
      check("post_hs_valid", 32'(result_valid), 32'd0);
      check("post_hs_start_ready", 32'(start_ready), 32'd1);
   endtask

   task automatic wait_step(input logic [3:0] k);
      int n;
      n = 0;
      while (!(busy === 1'b1 && step === k) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("reach_step", 32'(step), 32'(k));
   endtask

   // Start a job and abort it at step k; no result may follow
   task automatic abort_job(input logic [15:0] lm, input logic [15:0] cm,
                            input logic [3:0] last, input logic [3:0] k);
      offer(lm, cm, last);
      @(negedge clk);
      start_valid = 1'b0;
      wait_step(k);
      check("abort_busy_before", 32'(busy), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_start_ready", 32'(start_ready), 32'd1);
      check("abort_no_valid", 32'(result_valid), 32'd0);
      check("abort_step", 32'(step), 32'd0);
      repeat (3) @(negedge clk);
      check("abort_still_idle", 32'(result_valid), 32'd0);
   endtask

   initial begin : driver
      reset         = 1'b0;
      start_valid   = 1'b0;
      cfg_load_mask = '0;
      cfg_cnt_mask  = '0;
      cfg_last      = '0;
      abort         = 1'b0;
      result_ready  = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_start_ready", 32'(start_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(result_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_step", 32'(step), 32'd0);
      reset = 1'b1;

      do_job(16'h425F, 16'h3FFD, 4'd14, 6'd33, 0, 1'b0);   // legacy sequence
      do_job(16'hFFFF, 16'hFFFF, 4'd15, 6'd56, 0, 1'b0);   // full run, 120 mod 64
      do_job(16'h0001, 16'h0001, 4'd0,  6'd0,  0, 1'b0);   // single step
      do_job(16'h000A, 16'h0005, 4'd3,  6'd3,  0, 1'b0);   // alternating
      do_job(16'h425F, 16'h3FFD, 4'd14, 6'd33, 5, 1'b0);   // backpressure, abort in DONE ignored
      do_job(16'h425F, 16'h3FFD, 4'd14, 6'd33, 0, 1'b1);   // config changed after accept

      abort_job(16'h425F, 16'h3FFD, 4'd14, 4'd3);          // abort mid-run
      abort_job(16'hFFFF, 16'hFFFF, 4'd2,  4'd2);          // abort on final step

      // Reset asserted mid-run
      offer(16'h425F, 16'h3FFD, 4'd14);
      @(negedge clk);
      start_valid = 1'b0;
      wait_step(4'd7);
      #1 reset = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_valid", 32'(result_valid), 32'd0);
      check("midrst_step", 32'(step), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      check("midrst_start_ready", 32'(start_ready), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      do_job(16'h425F, 16'h3FFD, 4'd14, 6'd33, 0, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/acc_sched.md
ACC_SCHED -- requirements
Module: acc_sched

Interface
REQ-001 The block SHALL use parameter STEPS, default 16, meaning the maximum number of sequence steps per job.
REQ-002 The block SHALL use parameter DW, default 6, meaning the accumulator and counter width.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start_valid, input, 1 bit: the requester offers a job.
REQ-006 Port start_ready, output, 1 bit: the block can accept a job.
REQ-007 Port cfg_load_mask, input, STEPS bits: bit k set means W <= W + B at step k.
REQ-008 Port cfg_cnt_mask, input, STEPS bits: bit k set means B <= B + 1 at step k.
REQ-009 Port cfg_last, input, 4 bits: index of the final step (0..STEPS-1).
REQ-010 Port abort, input, 1 bit: cancels a running job.
REQ-011 Port result_valid, output, 1 bit: result holds a completed job value.
REQ-012 Port result_ready, input, 1 bit: the consumer accepts the result.
REQ-013 Port result, output, DW bits: final accumulator W.
REQ-014 Port busy, output, 1 bit: high when the FSM is not in IDLE.
REQ-015 Port step, output, 4 bits: current step index during RUN, 0 otherwise.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, RUN and DONE.
REQ-017 Job acceptance: start_ready SHALL be high only in IDLE; accept = start_valid && start_ready; on accept, the block SHALL latch both masks and cfg_last and SHALL move to CLEAR.
REQ-018 CLEAR SHALL last one cycle, set W=0, B=0 and step=0, then move to RUN.
REQ-019 At each RUN cycle k, the block SHALL apply the load and count operations selected by the latched masks simultaneously, both using pre-edge W and B.
REQ-020 After step cfg_last is applied, the block SHALL move to DONE; if step k < cfg_last, it SHALL increment step.
REQ-021 Latency: with accept at edge E0, result_valid SHALL be high after edge E0+cfg_last+2.
REQ-022 All arithmetic SHALL be modulo 2^DW (wrap-around, no saturation, no overflow flag).
REQ-023 In DONE, result_valid SHALL be 1 and result SHALL equal W, held stable until result_ready; on the handshake the block SHALL go to IDLE and result_valid SHALL drop.
REQ-024 Inputs changing after accept SHALL not affect a running job.
REQ-025 abort in CLEAR or RUN SHALL return the FSM to IDLE at the next edge with no result_valid; abort in IDLE or DONE SHALL be ignored.
REQ-026 If abort and the final step coincide, abort SHALL win.
REQ-027 A new job SHALL be accepted no earlier than the cycle after the result handshake (start_ready is high in IDLE only).
REQ-028 With cfg_last=0, exactly one step SHALL execute.

Reset
REQ-029 On reset low, the block SHALL immediately force state=IDLE, W=0, B=0, step=0, result_valid=0 and busy=0, including mid-job; start_ready SHALL be 1 from the first edge after reset releases.
REQ-030 Latched configuration registers SHALL reset to 0.

Structure
REQ-031 Package acc_sched_pkg SHALL hold the state enum type, STEPS and DW defaults, and the step index width.
REQ-032 Sub-module acc_dp SHALL hold the W and B registers with inputs clr, load_w and cnt, and output W; acc_sched SHALL contain the FSM and config latches only.

Verification
REQ-033 Legacy sequence: load_mask=0x425F, cnt_mask=0x3FFD, last=14 -> result=33, result_valid after edge E0+16.
REQ-034 Full run: both masks=0xFFFF, last=15 -> result=56 (120 mod 64).
REQ-035 Minimal job: last=0, load_mask=0x0001, cnt_mask=0x0001 -> result=0; result_valid after E0+2.
REQ-036 Backpressure and abort: hold result_ready=0 for 5 cycles -> result stable and start_ready=0 throughout; separately, assert abort at RUN step 3 -> IDLE next edge and no result_valid.
REQ-037 Reset mid-RUN at step 7 -> all outputs zero asynchronously; next job (legacy masks) -> result=33.
REQ-038 Config change after accept: change masks to 0 on the cycle after accept -> result still matches the latched configuration.
